// File: rtl/memoria_dados.sv
// Wait-stated data memory: one request at a time, accepted in IDLE and completed
// after WAIT_CYCLES wait states plus one ACCESS cycle, with a ready/err handshake.
module memoria_dados #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd,
    input  logic              we,
    input  logic [ADDR_W-1:0] endereco,
    input  logic [DATA_W-1:0] dataInMem,
    output logic [DATA_W-1:0] dataOutMem,
    output logic              busy,
    output logic              ready,
    output logic              err
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned CntW  = 4;

    typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              is_write_q;
    logic [DATA_W-1:0] mem_q [Depth];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            busy       <= 1'b0;
            ready      <= 1'b0;
            err        <= 1'b0;
            dataOutMem <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rd ^ we) begin
                        addr_q     <= endereco;
                        wdata_q    <= dataInMem;
                        is_write_q <= we;
                        cnt_q      <= CntW'(WAIT_CYCLES);
                        busy       <= 1'b1;
                        state_q    <= (WAIT_CYCLES > 0) ? StWait : StAccess;
                    end else if (rd && we) begin
                        // Conflicting request: flag it and stay put.
                        err <= 1'b1;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (is_write_q) begin
                        mem_q[addr_q] <= wdata_q;
                    end else begin
                        dataOutMem <= mem_q[addr_q];
                    end
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memoria_dados.sv
// Scoreboard bench for memoria_dados: default-parameter instance plus a
// zero-wait-state instance for the WAIT_CYCLES=0 timing case.
module tb_memoria_dados;

    typedef struct packed {
        logic       is_rd;
        logic [7:0] exp_data;
    } sb_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rd = 1'b0, we = 1'b0;
    logic [3:0] endereco = '0;
    logic [7:0] dataInMem = '0;
    logic [7:0] dataOutMem;
    logic       busy, ready, err;

    logic       reset0 = 1'b1;
    logic       rd0 = 1'b0, we0 = 1'b0;
    logic [3:0] endereco0 = '0;
    logic [7:0] data_in0 = '0;
    logic [7:0] data_out0;
    logic       busy0, ready0, err0;

    int   n_checks = 0;
    int   n_pass = 0;
    int   ready_cnt = 0;
    int   rc;
    int   bc;
    sb_t  sb[$];
    logic [7:0] model [16];
    logic [7:0] last_rd;

    always #5 clock = ~clock;

    memoria_dados #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .rd         (rd),
        .we         (we),
        .endereco   (endereco),
        .dataInMem  (dataInMem),
        .dataOutMem (dataOutMem),
        .busy       (busy),
        .ready      (ready),
        .err        (err)
    );

    memoria_dados #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(0)) dut0 (
        .clock      (clock),
        .reset      (reset0),
        .rd         (rd0),
        .we         (we0),
        .endereco   (endereco0),
        .dataInMem  (data_in0),
        .dataOutMem (data_out0),
        .busy       (busy0),
        .ready      (ready0),
        .err        (err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        last_rd = 8'h00;
    endtask

    // Drive a request and, when it is a legal single request, record what
    // dataOutMem must show at its ready pulse.
    task automatic request(input logic r, input logic w, input logic [3:0] a,
                           input logic [7:0] d);
        rd = r; we = w; endereco = a; dataInMem = d;
        if (w && !r) begin
            model[a] = d;
            sb.push_back('{is_rd: 1'b0, exp_data: last_rd});
        end else if (r && !w) begin
            last_rd = model[a];
            sb.push_back('{is_rd: 1'b1, exp_data: model[a]});
        end
    endtask

    task automatic release_bus();
        rd = 1'b0; we = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (ready !== 1'b1) check(tag, ready, 1);
    endtask

    always @(negedge clock) begin
        sb_t e;
        if (ready === 1'b1) begin
            ready_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_ready", ready, 0);
            end else begin
                e = sb.pop_front();
                check(e.is_rd ? "read_data" : "data_hold_on_write", dataOutMem, e.exp_data);
            end
        end
    end

    initial begin
        clear_model();
        repeat (2) step();
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_err", err, 0);
        check("rst_dout", dataOutMem, 8'h00);

        // Read of 0x5 issued in the first cycle after reset drops
        reset = 1'b0;
        request(1'b1, 1'b0, 4'h5, 8'h00);
        step();
        release_bus();
        bc = 0;
        while (busy === 1'b1 && bc < 20) begin
            bc++;
            step();
        end
        check("busy_cycles", bc, 3);
        check("ready_after_busy", ready, 1);
        step();
        check("ready_pulse_width", ready, 0);

        // Write then back-to-back read accepted in the write's ready cycle
        request(1'b0, 1'b1, 4'h3, 8'hA7);
        step();
        release_bus();
        wait_ready("wr_ready_timeout");
        request(1'b1, 1'b0, 4'h3, 8'h00);
        step();
        check("b2b_accept", busy, 1);
        release_bus();
        wait_ready("b2b_ready_timeout");
        step();

        // Conflicting rd/we in IDLE
        rc = ready_cnt;
        request(1'b1, 1'b1, 4'h3, 8'hFF);
        step();
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        release_bus();
        step();
        check("err_width", err, 0);
        check("err_no_busy", busy, 0);
        check("err_no_ready", ready_cnt - rc, 0);
        request(1'b1, 1'b0, 4'h3, 8'h00);
        step();
        release_bus();
        wait_ready("err_readback_timeout");
        step();

        // Inputs toggled while busy must be ignored
        rc = ready_cnt;
        request(1'b0, 1'b1, 4'h9, 8'h5C);
        step();
        rd = 1'b1; we = 1'b0; endereco = 4'h1; dataInMem = 8'hFF;
        step();
        rd = 1'b0; we = 1'b1;
        step();
        rd = 1'b1; we = 1'b1;
        wait_ready("glitch_ready_timeout");
        release_bus();
        endereco = 4'h0; dataInMem = 8'h00;
        repeat (3) step();
        check("glitch_one_ready", ready_cnt - rc, 1);
        request(1'b1, 1'b0, 4'h9, 8'h00);
        step();
        release_bus();
        wait_ready("rd9_timeout");
        step();
        request(1'b1, 1'b0, 4'h1, 8'h00);
        step();
        release_bus();
        wait_ready("rd1_timeout");
        step();

        // Reset in the second WAIT cycle aborts the write
        request(1'b0, 1'b1, 4'hF, 8'h11);
        step();
        release_bus();
        step();
        reset = 1'b1;
        sb.delete();
        rc = ready_cnt;
        step();
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        check("abort_dout", dataOutMem, 8'h00);
        reset = 1'b0;
        clear_model();
        repeat (4) step();
        check("abort_no_ready", ready_cnt - rc, 0);
        request(1'b1, 1'b0, 4'hF, 8'h00);
        step();
        release_bus();
        wait_ready("abort_readback_timeout");
        step();

        // Zero wait states
        reset0 = 1'b0;
        we0 = 1'b1; endereco0 = 4'h0; data_in0 = 8'h80;
        step();
        we0 = 1'b0;
        check("w0_busy", busy0, 1);
        check("w0_ready_early", ready0, 0);
        step();
        check("w0_busy_end", busy0, 0);
        check("w0_ready", ready0, 1);
        rd0 = 1'b1; endereco0 = 4'h0;
        step();
        rd0 = 1'b0;
        check("r0_busy", busy0, 1);
        step();
        check("r0_ready", ready0, 1);
        check("r0_data", data_out0, 8'h80);

        check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
